// File: rtl/sand_reg_writer.sv
// Buffers register-update requests in a FIFO and replays them as one-cycle writes on the sand/ball register bus.
// Optional build macro: SAND_WR_WAITREQ_EN enables slave stalling through waitrequest.
module sand_reg_writer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_addr,
    input  logic [7:0]               req_data,
    input  logic                     hold,
    input  logic                     waitrequest,
    output logic                     chipselect,
    output logic                     write,
    output logic [2:0]               address,
    output logic [7:0]               writedata,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bad_addr
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned NUM_REGS = 5;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state_q,    state_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic            ready_q,    ready_d;
    logic            cs_q,       cs_d;
    logic [2:0]      addr_q,     addr_d;
    logic [7:0]      data_q,     data_d;
    logic            busy_q,     busy_d;
    logic            bad_addr_q, bad_addr_d;
    wr_entry_t       mem_q [DEPTH];
    wr_entry_t       mem_d [DEPTH];

    logic            accept_c;
    logic            addr_ok_c;
    logic            push_c;
    logic            pop_c;
    logic            xfer_done_c;
    logic            fifo_avail_c;
    wr_entry_t       head_c;

    // A write completes on every strobe cycle unless the slave may stall it.
`ifdef SAND_WR_WAITREQ_EN
    assign xfer_done_c = cs_q && !waitrequest;
`else
    logic unused_waitreq;
    assign unused_waitreq = waitrequest;
    assign xfer_done_c    = cs_q;
`endif

    // Request side: ready comes only from the registered full flag.
    always_comb begin
        accept_c     = req_valid && ready_q;
        addr_ok_c    = (req_addr < 3'(NUM_REGS));
        push_c       = accept_c && addr_ok_c;
        fifo_avail_c = (count_q != '0);
        head_c       = mem_q[rd_ptr_q];
    end

    // Bus FSM: decides when the head entry is popped onto the strobe registers.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        addr_d  = addr_q;
        data_d  = data_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_avail_c && !hold) begin
                    pop_c   = 1'b1;
                    state_d = XFER;
                    cs_d    = 1'b1;
                    addr_d  = head_c.addr;
                    data_d  = head_c.data;
                end
            end
            XFER: begin
                if (xfer_done_c) begin
                    if (fifo_avail_c && !hold) begin
                        pop_c  = 1'b1;
                        addr_d = head_c.addr;
                        data_d = head_c.data;
                    end else begin
                        state_d = IDLE;
                        cs_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping and status flags.
    always_comb begin
        wr_ptr_d   = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        ready_d    = (count_d != CW'(DEPTH));
        busy_d     = (count_d != '0) || cs_d;
        bad_addr_d = bad_addr_q || (accept_c && !addr_ok_c);
    end

    always_comb begin
        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = '{addr: req_addr, data: req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            cs_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign req_ready  = ready_q;
    assign chipselect = cs_q;
    assign write      = cs_q;
    assign address    = addr_q;
    assign writedata  = data_q;
    assign busy       = busy_q;
    assign count      = count_q;
    assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_sand_reg_writer.sv
// Scoreboard bench for sand_reg_writer: directed pushes queue expected bus writes, a monitor checks each strobe.
module tb_sand_reg_writer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_addr;
    logic [7:0]  req_data;
    logic        hold;
    logic        waitrequest;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic        busy;
    logic [$clog2(DEPTH):0] count;
    logic        bad_addr;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total      = 0;
    int   bad        = 0;
    int   strobe_cnt = 0;
    int   s0;

    sand_reg_writer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .hold        (hold),
        .waitrequest (waitrequest),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .busy        (busy),
        .count       (count),
        .bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle request; the expected bus write is queued only when it should be pushed.
    task automatic push_one(input logic [2:0] a, input logic [7:0] d, input bit expect_wr);
        if (expect_wr) exp_q.push_back('{a: a, d: d});
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        cyc(1);
        req_valid = 1'b0;
    endtask

    // Monitor: every completed strobe cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (chipselect && !waitrequest) begin
            exp_t e;
            strobe_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", address, writedata);
            end else begin
                e = exp_q.pop_front();
                if ({write, address, writedata} !== {1'b1, e.a, e.d}) begin
                    bad++;
                    $display("FAIL bus_write: got wr=%0b addr=%0h data=%0h expected wr=1 addr=%0h data=%0h",
                             write, address, writedata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        hold        = 1'b0;
        waitrequest = 1'b0;
        cyc(2);
        reset = 1'b0;

        // Reset values
        chk("rst_ready", req_ready, 1);
        chk("rst_cs", chipselect, 0);
        chk("rst_wr", write, 0);
        chk("rst_addr", address, 0);
        chk("rst_data", writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_bad", bad_addr, 0);

        // Single write: strobe one cycle after acceptance
        s0 = strobe_cnt;
        push_one(3'd3, 8'h55, 1);
        chk("single_cs_accept", chipselect, 0);
        chk("single_count", count, 1);
        chk("single_busy", busy, 1);
        cyc(1);
        chk("single_cs", chipselect, 1);
        chk("single_wr", write, 1);
        chk("single_addr", address, 3);
        chk("single_data", writedata, 8'h55);
        cyc(1);
        chk("single_cs_drop", chipselect, 0);
        chk("single_busy_drop", busy, 0);
        chk("single_keep_addr", address, 3);
        cyc(2);
        chk("single_strobes", strobe_cnt - s0, 1);

        // Burst to full while held, fifth request refused
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_one(3'(i), 8'h10 + 8'(i), 1);
        chk("full_ready", req_ready, 0);
        chk("full_count", count, 4);
        push_one(3'd4, 8'hEE, 0);
        chk("full_count_after5", count, 4);
        chk("full_cs_held", chipselect, 0);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("burst_cs", chipselect, 1);
            chk("burst_addr", address, i);
            chk("burst_count", count, 3 - i);
            chk("burst_ready", req_ready, 1);
        end
        cyc(1);
        chk("burst_cs_end", chipselect, 0);
        chk("burst_busy_end", busy, 0);

        // Streaming: push and pop in the same cycle keep count steady
        push_one(3'd0, 8'hA1, 1);
        push_one(3'd1, 8'hA2, 1);
        chk("stream_count1", count, 1);
        chk("stream_cs1", chipselect, 1);
        push_one(3'd2, 8'hA3, 1);
        chk("stream_count2", count, 1);
        chk("stream_addr2", address, 1);
        cyc(1);
        chk("stream_addr3", address, 2);
        chk("stream_count3", count, 0);
        cyc(1);
        chk("stream_cs_end", chipselect, 0);

        // Bad address: consumed, not queued, sticky flag
        s0 = strobe_cnt;
        push_one(3'd6, 8'h66, 0);
        chk("bad_flag", bad_addr, 1);
        chk("bad_count", count, 0);
        cyc(3);
        chk("bad_no_strobe", strobe_cnt - s0, 0);
        push_one(3'd2, 8'h22, 1);
        cyc(3);
        chk("bad_sticky", bad_addr, 1);

        // Hold raised after the first strobe of three
        hold = 1'b1;
        push_one(3'd4, 8'h41, 1);
        push_one(3'd0, 8'h42, 1);
        push_one(3'd1, 8'h43, 1);
        s0   = strobe_cnt;
        hold = 1'b0;
        cyc(1);
        hold = 1'b1;
        chk("hold_first_cs", chipselect, 1);
        chk("hold_first_addr", address, 4);
        cyc(4);
        chk("hold_cs_off", chipselect, 0);
        chk("hold_count", count, 2);
        chk("hold_strobes", strobe_cnt - s0, 1);
        hold = 1'b0;
        cyc(1);
        chk("hold_second_addr", address, 0);
        cyc(1);
        chk("hold_third_addr", address, 1);
        chk("hold_third_cs", chipselect, 1);
        cyc(1);
        chk("hold_done_cs", chipselect, 0);
        chk("hold_strobes_all", strobe_cnt - s0, 3);

        // Reset during a strobe with two queued; concurrent request is dropped
        hold = 1'b1;
        push_one(3'd1, 8'h71, 1);
        push_one(3'd2, 8'h72, 0);
        push_one(3'd3, 8'h73, 0);
        hold = 1'b0;
        cyc(1);
        chk("rstx_cs", chipselect, 1);
        chk("rstx_count", count, 2);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 3'd2;
        req_data  = 8'h99;
        cyc(1);
        reset     = 1'b0;
        req_valid = 1'b0;
        chk("rstx_cs_after", chipselect, 0);
        chk("rstx_wr_after", write, 0);
        chk("rstx_count_after", count, 0);
        chk("rstx_ready_after", req_ready, 1);
        chk("rstx_busy_after", busy, 0);
        chk("rstx_bad_cleared", bad_addr, 0);
        s0 = strobe_cnt;
        cyc(5);
        chk("rstx_no_stale", strobe_cnt - s0, 0);

`ifdef SAND_WR_WAITREQ_EN
        // Stalled write holds the bus for four cycles and pops once
        hold = 1'b1;
        push_one(3'd1, 8'hA0, 1);
        push_one(3'd2, 8'h0B, 1);
        hold = 1'b0;
        cyc(1);
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("wait_cs", chipselect, 1);
            chk("wait_addr", address, 1);
            chk("wait_data", writedata, 8'hA0);
            chk("wait_count", count, 1);
            cyc(1);
        end
        waitrequest = 1'b0;
        chk("wait_last_addr", address, 1);
        chk("wait_last_count", count, 1);
        cyc(1);
        chk("wait_next_addr", address, 2);
        chk("wait_next_data", writedata, 8'h0B);
        chk("wait_next_count", count, 0);
        cyc(2);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
